// File: rtl/line_mem_pkg.sv
// Shared types and constants for the 256-bit cache-line memory responder.
package line_mem_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = 4;
  localparam int OFFSET_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_DRAIN,
    S_RESP,
    S_DONE
  } lm_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } lm_op_t;

endpackage

// File: rtl/line_mem_responder.sv
// Physical-memory end of the cache-line port: one line request at a time, programmable
// access latency, then four 64-bit beats to/from an external single-port word SRAM.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter  int DEPTH_LINES = 256,
  parameter  int LATENCY     = 4,
  localparam int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         address,
  input  logic [LINE_W-1:0]   wdata,
  output logic                resp,
  output logic [LINE_W-1:0]   rdata,
  output logic                err,
  output logic [IDX_W+1:0]    mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [BEAT_W-1:0]   mem_wdata,
  input  logic [BEAT_W-1:0]   mem_rdata
);

  localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_LOAD = (LATENCY > 0) ? LATENCY - 1 : 0;

  lm_state_t           state_q, state_d;
  lm_op_t              op_q, op_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    lat_q, lat_d;
  logic [1:0]          beat_q, beat_d;
  logic [1:0]          prev_beat;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [LINE_W-1:0]   rline_q, rline_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                resp_q, resp_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [IDX_W+1:0]    mem_addr_q, mem_addr_d;
  logic [BEAT_W-1:0]   mem_wdata_q, mem_wdata_d;

  // Offset bits and aliased upper address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[OFFSET_W-1:0], address[31:OFFSET_W+IDX_W]};

  always_comb begin
    // NOTE: every always_comb target gets a default before any branch, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    lat_d     = lat_q;
    beat_d    = beat_q;
    wline_d   = wline_q;
    rline_d   = rline_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    prev_beat = beat_q - 2'd1;

    unique case (state_q)
      S_IDLE: begin
        if (read || write) begin
          op_d    = write ? OP_WRITE : OP_READ;
          idx_d   = address[OFFSET_W +: IDX_W];
          wline_d = wdata;
          err_d   = err_q | (read & write);
          lat_d   = CNT_W'(LAT_LOAD);
          beat_d  = 2'd0;
          state_d = (LATENCY == 0) ? S_XFER : S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == '0) state_d = S_XFER;
        else             lat_d   = lat_q - 1'b1;
      end
      S_XFER: begin
        // SRAM data trails its read enable by one cycle, so beat k-1 lands while beat k issues.
        if (op_q == OP_READ && beat_q != 2'd0)
          rline_d[BEAT_W*prev_beat +: BEAT_W] = mem_rdata;
        if (beat_q == 2'd3) state_d = (op_q == OP_READ) ? S_DRAIN : S_RESP;
        else                beat_d  = beat_q + 2'd1;
      end
      S_DRAIN: begin
        rline_d[LINE_W-1 -: BEAT_W] = mem_rdata;
        rdata_d = {mem_rdata, rline_q[LINE_W-BEAT_W-1:0]};
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    resp_d      = (state_d == S_RESP);
    mem_re_d    = (state_d == S_XFER) && (op_d == OP_READ);
    mem_we_d    = (state_d == S_XFER) && (op_d == OP_WRITE);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == S_XFER) begin
      mem_addr_d = {idx_d, beat_d};
      if (op_d == OP_WRITE) mem_wdata_d = wline_d[BEAT_W*beat_d +: BEAT_W];
    end
  end

  // NOTE: the line registers are reset along with the control state so that rdata reads
  // back as zero after reset rather than stale contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      idx_q       <= '0;
      lat_q       <= '0;
      beat_q      <= '0;
      wline_q     <= '0;
      rline_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      resp_q      <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      beat_q      <= beat_d;
      wline_q     <= wline_d;
      rline_q     <= rline_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      resp_q      <= resp_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign resp      = resp_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: two instances (LATENCY 4 and 0) each backed by a
// 1-cycle-latency word SRAM, checked against a line-level reference model.
module tb_line_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic [31:0]  address = '0;
  logic [255:0] wdata = '0;

  logic         rd_s [2];
  logic         wr_s [2];
  logic         resp_s [2];
  logic         err_s [2];
  logic         mem_re_s [2];
  logic         mem_we_s [2];
  logic [255:0] rdata_s [2];
  logic [9:0]   mem_addr_s [2];
  logic [63:0]  mem_wdata_s [2];
  logic [63:0]  mem_rdata_s [2];
  logic [63:0]  sram [2][1024];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    line_mem_responder #(
      .DEPTH_LINES(256),
      .LATENCY    ((g == 0) ? 4 : 0)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .read     (rd_s[g]),
      .write    (wr_s[g]),
      .address  (address),
      .wdata    (wdata),
      .resp     (resp_s[g]),
      .rdata    (rdata_s[g]),
      .err      (err_s[g]),
      .mem_addr (mem_addr_s[g]),
      .mem_re   (mem_re_s[g]),
      .mem_we   (mem_we_s[g]),
      .mem_wdata(mem_wdata_s[g]),
      .mem_rdata(mem_rdata_s[g])
    );
  end

  // Word SRAM models: write on the edge, registered read data one cycle later.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_we_s[i]) sram[i][mem_addr_s[i]] <= mem_wdata_s[i];
      if (mem_re_s[i]) mem_rdata_s[i] <= sram[i][mem_addr_s[i]];
    end
  end

  // Reference model: whole lines per index, plus the expected sticky error flag.
  logic [255:0] ref_line [2][256];
  bit           ref_valid [2][256];
  bit           err_exp [2];
  int           n_checks = 0;
  int           n_fail = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  // Cycles from acceptance to resp: WAIT, four XFER beats, DRAIN for reads, then RESP.
  function automatic int exp_lat(input int i, input bit is_write);
    return lat_of(i) + (is_write ? 5 : 6);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] addr_for(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[12:5] = idx[7:0];
    return a;
  endfunction

  // Drives one request from a negedge with the DUT idle; checks the SRAM-side beats on the
  // way. Returns at the IDLE-cycle negedge (or the DONE-cycle negedge when hold is set).
  task automatic run_txn(input int i, input bit rq, input bit wq, input logic [31:0] a,
                         input logic [255:0] wd, input bit hold,
                         output int lat, output logic [255:0] line_o, output int beats);
    int first_beat, last_beat;
    logic [7:0]  idx;
    logic [9:0]  exp_addr;
    logic [63:0] wbeat;
    idx = a[12:5];
    lat = -1; beats = 0; first_beat = -1; last_beat = -1; line_o = '0;
    address = a; wdata = wd; rd_s[i] = rq; wr_s[i] = wq;
    @(posedge clk);
    #1;
    address = $urandom;
    wdata = rand_line();
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (mem_re_s[i] && mem_we_s[i]) begin
        n_checks++; n_fail++;
        $display("FAIL sram_re_we_overlap: dut%0d got re=1 we=1 expected not both", i);
      end
      if (mem_re_s[i] || mem_we_s[i]) begin
        exp_addr = {idx, beats[1:0]};
        n_checks++;
        if (mem_addr_s[i] !== exp_addr) begin
          n_fail++;
          $display("FAIL mem_addr: dut%0d beat %0d got %h expected %h", i, beats, mem_addr_s[i], exp_addr);
        end
        if (mem_we_s[i]) begin
          wbeat = wd[64*beats[1:0] +: 64];
          n_checks++;
          if (mem_wdata_s[i] !== wbeat) begin
            n_fail++;
            $display("FAIL mem_wdata: dut%0d beat %0d got %h expected %h", i, beats, mem_wdata_s[i], wbeat);
          end
        end
        if (first_beat < 0) first_beat = n;
        last_beat = n;
        beats++;
      end
      if (resp_s[i]) begin
        lat = n;
        line_o = rdata_s[i];
        break;
      end
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout: dut%0d got no resp expected one within 40 cycles", i);
    end
    n_checks++;
    if (beats != 0 && (last_beat - first_beat + 1) != beats) begin
      n_fail++;
      $display("FAIL beats_contiguous: dut%0d got span %0d expected %0d", i, last_beat - first_beat + 1, beats);
    end
    if (!hold) begin
      rd_s[i] = 1'b0;
      wr_s[i] = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (resp_s[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_one_cycle: dut%0d got resp=%b one cycle later expected 0", i, resp_s[i]);
    end
    if (!hold) @(negedge clk);
  endtask

  // Full write or read with latency, beat count, data and err checked against the model.
  task automatic model_txn(input int i, input bit is_write, input logic [31:0] a, input string tag);
    int lat, beats, idx;
    logic [255:0] line_o, wd;
    idx = int'(a[12:5]);
    wd = rand_line();
    run_txn(i, !is_write, is_write, a, wd, 1'b0, lat, line_o, beats);
    n_checks++;
    if (lat !== exp_lat(i, is_write)) begin
      n_fail++;
      $display("FAIL %s_latency: dut%0d got %0d expected %0d", tag, i, lat, exp_lat(i, is_write));
    end
    n_checks++;
    if (beats !== 4) begin
      n_fail++;
      $display("FAIL %s_beats: dut%0d got %0d expected 4", tag, i, beats);
    end
    if (is_write) begin
      ref_line[i][idx] = wd;
      ref_valid[i][idx] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (sram[i][idx*4+k] !== wd[64*k +: 64]) begin
          n_fail++;
          $display("FAIL %s_sram_word: dut%0d word %0d got %h expected %h", tag, i, idx*4+k, sram[i][idx*4+k], wd[64*k +: 64]);
        end
      end
    end else begin
      n_checks++;
      if (line_o !== ref_line[i][idx]) begin
        n_fail++;
        $display("FAIL %s_rdata: dut%0d got %h expected %h", tag, i, line_o, ref_line[i][idx]);
      end
    end
    n_checks++;
    if (err_s[i] !== err_exp[i]) begin
      n_fail++;
      $display("FAIL %s_err: dut%0d got %b expected %b", tag, i, err_s[i], err_exp[i]);
    end
  endtask

  task automatic check_reset_outputs(input int i, input string tag);
    n_checks++;
    if ({resp_s[i], err_s[i], mem_re_s[i], mem_we_s[i]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s_ctrl: dut%0d got resp/err/re/we=%b%b%b%b expected 0000", tag, i, resp_s[i], err_s[i], mem_re_s[i], mem_we_s[i]);
    end
    n_checks++;
    if (rdata_s[i] !== '0) begin
      n_fail++;
      $display("FAIL %s_rdata: dut%0d got %h expected 0", tag, i, rdata_s[i]);
    end
    n_checks++;
    if (mem_addr_s[i] !== '0 || mem_wdata_s[i] !== '0) begin
      n_fail++;
      $display("FAIL %s_mem_bus: dut%0d got addr %h wdata %h expected 0", tag, i, mem_addr_s[i], mem_wdata_s[i]);
    end
  endtask

  task automatic test_reset();
    rd_s[0] = 1'b0; wr_s[0] = 1'b0; rd_s[1] = 1'b0; wr_s[1] = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_reset_outputs(i, "reset");
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat, beats;
    logic [255:0] wd, line_o;
    wd = {64'hD, 64'hC, 64'hB, 64'hA};
    run_txn(0, 1'b0, 1'b1, 32'h0000_0040, wd, 1'b0, lat, line_o, beats);
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL wr_latency: got %0d expected 9", lat);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (sram[0][8+k] !== 64'(10 + k)) begin
        n_fail++;
        $display("FAIL wr_sram_word: word %0d got %h expected %h", 8 + k, sram[0][8+k], 64'(10 + k));
      end
    end
    ref_line[0][2] = wd;
    ref_valid[0][2] = 1'b1;
    run_txn(0, 1'b1, 1'b0, 32'h0000_0040, rand_line(), 1'b0, lat, line_o, beats);
    n_checks++;
    if (lat !== 10) begin
      n_fail++;
      $display("FAIL rd_latency: got %0d expected 10", lat);
    end
    n_checks++;
    if (line_o !== wd) begin
      n_fail++;
      $display("FAIL rd_line: got %h expected %h", line_o, wd);
    end
  endtask

  task automatic test_zero_latency();
    logic [31:0] a;
    a = addr_for(37);
    model_txn(1, 1'b1, a, "zl_preload");
    model_txn(1, 1'b0, a, "zl_read");
  endtask

  task automatic test_aliasing();
    model_txn(0, 1'b1, 32'h0000_2040, "alias_wr");
    model_txn(0, 1'b0, 32'h0000_0040, "alias_rd");
  endtask

  task automatic test_held_request();
    int lat, beats;
    bit seen;
    logic [255:0] line_o;
    run_txn(0, 1'b1, 1'b0, 32'h0000_0040, rand_line(), 1'b1, lat, line_o, beats);
    // Request still high through the whole DONE cycle, then released.
    @(posedge clk);
    #1 rd_s[0] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (resp_s[0] || mem_re_s[0]) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL held_reaccept: got resp/mem_re activity expected none after release");
    end
    model_txn(0, 1'b0, 32'h0000_0040, "held_next");
  endtask

  task automatic test_back_to_back();
    int lat, beats, gap;
    logic [255:0] line_o;
    logic [31:0] b;
    model_txn(0, 1'b1, addr_for(9), "b2b_prep");
    run_txn(0, 1'b1, 1'b0, 32'h0000_0040, rand_line(), 1'b1, lat, line_o, beats);
    b = addr_for(9);
    address = b;
    gap = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (resp_s[0]) begin
        gap = n;
        line_o = rdata_s[0];
        break;
      end
    end
    rd_s[0] = 1'b0;
    // DONE cycle plus one IDLE cycle precede the re-acceptance.
    n_checks++;
    if (gap !== exp_lat(0, 1'b0) + 1) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d expected %0d", gap, exp_lat(0, 1'b0) + 1);
    end
    n_checks++;
    if (line_o !== ref_line[0][9]) begin
      n_fail++;
      $display("FAIL b2b_rdata: got %h expected %h", line_o, ref_line[0][9]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_illegal();
    int lat, beats, idx;
    logic [255:0] wd, line_o;
    logic [31:0] a;
    idx = 77;
    a = addr_for(idx);
    wd = rand_line();
    run_txn(0, 1'b1, 1'b1, a, wd, 1'b0, lat, line_o, beats);
    err_exp[0] = 1'b1;
    ref_line[0][idx] = wd;
    ref_valid[0][idx] = 1'b1;
    n_checks++;
    if (lat !== exp_lat(0, 1'b1)) begin
      n_fail++;
      $display("FAIL illegal_latency: got %0d expected %0d", lat, exp_lat(0, 1'b1));
    end
    n_checks++;
    if (err_s[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_err: got %b expected 1", err_s[0]);
    end
    n_checks++;
    if (err_s[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_err_other: dut1 got %b expected 0", err_s[1]);
    end
    model_txn(0, 1'b0, a, "illegal_readback");
  endtask

  task automatic test_random();
    int i, idx;
    bit is_write;
    for (int t = 0; t < 40; t++) begin
      i = $urandom_range(0, 1);
      idx = $urandom_range(0, 15);
      is_write = ($urandom_range(0, 1) == 1) || !ref_valid[i][idx];
      model_txn(i, is_write, addr_for(idx), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_write();
    int idx;
    bit found;
    logic [255:0] old_line, new_line;
    logic [31:0] a;
    idx = 200;
    a = addr_for(idx);
    model_txn(0, 1'b1, a, "rst_prep");
    old_line = ref_line[0][idx];
    new_line = rand_line();
    address = a; wdata = new_line; wr_s[0] = 1'b1;
    @(posedge clk);
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (mem_we_s[0] && mem_addr_s[0][1:0] == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rst_find_beat2: got no beat-2 write expected one within 30 cycles");
    end
    reset = 1'b1;
    #1;
    check_reset_outputs(0, "rst_async");
    wr_s[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    err_exp[0] = 1'b0;
    err_exp[1] = 1'b0;
    ref_line[0][idx] = {old_line[255:128], new_line[127:0]};
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (sram[0][idx*4+k] !== ref_line[0][idx][64*k +: 64]) begin
        n_fail++;
        $display("FAIL rst_sram_word: beat %0d got %h expected %h", k, sram[0][idx*4+k], ref_line[0][idx][64*k +: 64]);
      end
    end
    @(negedge clk);
    model_txn(0, 1'b0, a, "rst_readback");
    n_checks++;
    if (err_s[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_err_other: dut1 got %b expected 0", err_s[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      err_exp[i] = 1'b0;
      for (int j = 0; j < 256; j++) begin
        ref_line[i][j] = '0;
        ref_valid[i][j] = 1'b0;
      end
    end
    test_reset();
    test_write_read();
    test_zero_latency();
    test_aliasing();
    test_held_request();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
